lfsr_interval_timer: RTL and testbench
======================================

Name: lfsr_interval_timer

Overview:
Parametrised successor to the fixed 100 ms / 1 s LFSR timers in the Braille trainer. An LFSR prescaler generates a base tick every TICK_DIV clocks. A programmable interval counter counts LIMIT ticks and then emits a one-cycle timeout, in either one-shot or periodic mode, with start/stop/restart control. It drives character-display and answer-window timing in the trainer FSMs.

Parameters:
LFSR_W, 7, prescaler LFSR width (maximal-length Fibonacci); TICK_DIV must satisfy 2 <= TICK_DIV <= 2^LFSR_W-1
TICK_DIV, 100, clocks per base tick
CNT_W, 4, width of interval counter and limit input

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  start/restart request, level-sampled each clk
stop  in  1  abort request
mode  in  1  0 = one-shot, 1 = periodic; latched on accepted start
limit  in  CNT_W  ticks per interval; latched on accepted start; 0 = invalid
tick  out  1  base-tick pulse, 1 cycle
count  out  CNT_W  ticks elapsed in current interval, 0..limit_q-1
timeout  out  1  interval-complete pulse, 1 cycle
busy  out  1  1 while in RUN

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; count=0, timeout=0, tick=0, busy=0; LFSR=all-ones seed; limit_q=0, mode_q=0. Reset overrides all other inputs.
- FSM states:
  - IDLE: start=1 and stop=0 and limit!=0 -> RUN. limit_q<=limit, mode_q<=mode, LFSR reseeded, count<=0. A start with limit=0 is ignored and the FSM stays in IDLE.
  - RUN: busy=1.
    - stop=1 -> IDLE next edge. count<=0. No timeout, even if a final tick coincides. stop has priority over start.
    - start=1 (stop=0, limit!=0) -> restart: reseed, relatch limit and mode, count<=0, pending tick discarded.
- Prescaler:
  - Advances one LFSR step per clk in RUN and holds in IDLE.
  - When the LFSR equals TERM (the state TICK_DIV-1 steps after the seed), tick<=1 at the next edge and the LFSR reseeds.
  - If the accepted start is sampled at edge E, ticks are visible after edges E+n*TICK_DIV.
- Interval counter, on a cycle with tick=1 in RUN:
  - If count != limit_q-1: count<=count+1.
  - Otherwise, at that edge: count<=0 and timeout<=1 for exactly one cycle.
    - One-shot: state<=IDLE and busy<=0 at the same edge.
    - Periodic: remain in RUN; the LFSR keeps running, so there is no phase slip.
- Latency: timeouts visible after edge E+k*limit_q*TICK_DIV+1. One-shot has k=1 only.
- Wrap-around: limit=2^CNT_W-1 is the maximum. count never reaches limit_q.
- Simultaneous events:
  - rst beats stop.
  - stop beats start.
  - stop beats the final tick.
  - start in RUN beats the final tick, so no timeout is emitted.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package lfsr_timer_pkg:
  - state enum {IDLE, RUN}
  - constant function lfsr_taps(width) returning the maximal-length tap mask for widths 3..16
  - constant function lfsr_term(width, div) returning TERM by stepping from the all-ones seed
  - SEED constant
- Sub-module lfsr_prescaler(clk, rst, en, reseed, tick), parametrised by LFSR_W and TICK_DIV. It is reusable by the existing fixed timers.

Test Plan:
1. Defaults, mode=0, limit=10, start at edge E -> tick after E+100, E+200, ...; count steps 1..9; timeout single pulse after E+1001; busy falls after E+1001.
2. TICK_DIV=5, mode=1, limit=3 -> timeout after E+16, E+31, E+46; count cycles 0,1,2; busy stays 1.
3. TICK_DIV=5, mode=1, limit=3, stop asserted on the final-tick cycle before E+16 -> no timeout; count=0, busy=0 after E+16.
4. TICK_DIV=5, one-shot, limit=4, start re-asserted with limit=2 at E+12 -> count=0 after E+13; timeout after E+23 only.
5. start with limit=0 -> busy, count and timeout all stay 0. rst=0 for 2 cycles mid-RUN -> all outputs 0 and IDLE; no tick until the next start.
6. TICK_DIV=2 and TICK_DIV=2^LFSR_W-1, limit=1 -> timeout period exactly TICK_DIV in periodic mode, verified by a cycle-count scoreboard.

Source files
------------

// File: rtl/lfsr_timer_pkg.sv
// Shared definitions for the LFSR interval timer family.
//   state_e    : controller states (IDLE, RUN)
//   SEED       : all-ones LFSR seed, truncated to the LFSR width by users
//   lfsr_taps  : maximal-length Fibonacci tap mask for widths 3..16
//   lfsr_term  : LFSR state reached div-1 steps after the seed; a prescaler
//                that reseeds on this state ticks every div clocks
package lfsr_timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int LFSR_MAX_W = 16;
    localparam logic [LFSR_MAX_W-1:0] SEED = '1;

    // Bit k of the mask selects register bit k (tap k+1 in 1-based notation).
    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int width);
        logic [LFSR_MAX_W-1:0] taps;
        case (width)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

    function automatic logic [LFSR_MAX_W-1:0] lfsr_term(input int width, input int div);
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] taps;
        logic [LFSR_MAX_W-1:0] s;
        mask = (16'h0001 << width) - 16'h0001;
        taps = lfsr_taps(width);
        s    = SEED & mask;
        for (int i = 1; i < div; i++) begin
            s = ((s << 1) | {15'd0, ^(s & taps)}) & mask;
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_interval_timer_prescaler.sv
// LFSR prescaler: emits a one-cycle tick every TICK_DIV enabled clocks.
//   clk    : clock
//   rst    : synchronous active-low reset, loads the all-ones seed
//   en     : advance the LFSR one step this clock
//   reseed : load the seed and drop any pending tick (wins over en)
//   tick   : registered pulse, high for one cycle each TICK_DIV clocks
// The LFSR replaces a binary down-counter so the compare is a single
// equality against a constant state computed at elaboration.
module lfsr_prescaler
    import lfsr_timer_pkg::*;
#(
    parameter int LFSR_W   = 7,
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic reseed,
    output logic tick
);

    localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [LFSR_W-1:0] SEED_W = LFSR_W'(SEED);
    localparam logic [LFSR_W-1:0] TERM   = LFSR_W'(lfsr_term(LFSR_W, TICK_DIV));

    logic [LFSR_W-1:0] lfsr;
    logic              fb;

    assign fb = ^(lfsr & TAPS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= SEED_W;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (reseed) begin
                lfsr <= SEED_W;
            end else if (en) begin
                if (lfsr == TERM) begin
                    lfsr <= SEED_W;
                    tick <= 1'b1;
                end else begin
                    lfsr <= {lfsr[LFSR_W-2:0], fb};
                end
            end
        end
    end

endmodule

// File: rtl/lfsr_interval_timer.sv
// Programmable interval timer built on the LFSR prescaler.
//   clk     : clock
//   rst     : synchronous active-low reset
//   start   : start / restart request (needs stop=0 and limit!=0)
//   stop    : abort; wins over start and over a coinciding final tick
//   mode    : 0 one-shot, 1 periodic; latched on an accepted start
//   limit   : ticks per interval; latched on an accepted start
//   tick    : base-tick pulse from the prescaler
//   count   : ticks elapsed in the current interval
//   timeout : one-cycle pulse when the interval completes
//   busy    : high while running
//
// state | meaning
// IDLE  | prescaler frozen, waiting for a valid start
// RUN   | prescaler running, counting ticks toward limit_q
module lfsr_interval_timer
    import lfsr_timer_pkg::*;
#(
    parameter int LFSR_W   = 7,
    parameter int TICK_DIV = 100,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] limit,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             timeout,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]       state;
    logic [CNT_W-1:0] limit_q;
    logic             mode_q;
    logic             start_ok;
    logic             running;
    logic             last_tick;

    assign start_ok  = start & ~stop & (limit != '0);
    assign running   = (state == ST_RUN);
    assign last_tick = (count == limit_q - CNT_W'(1));
    assign busy      = running;

    // A stop freezes the prescaler so a tick cannot surface after the abort.
    lfsr_prescaler #(
        .LFSR_W   (LFSR_W),
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (running & ~stop),
        .reseed (start_ok),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            timeout <= 1'b0;
            limit_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state   <= ST_RUN;
                        limit_q <= limit;
                        mode_q  <= mode;
                        count   <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else if (start_ok) begin
                        limit_q <= limit;
                        mode_q  <= mode;
                        count   <= '0;
                    end else if (tick) begin
                        if (last_tick) begin
                            count   <= '0;
                            timeout <= 1'b1;
                            if (!mode_q) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_interval_timer.sv
module tb_lfsr_interval_timer;

    localparam int CNT_W = 4;
    localparam int NDUT  = 4;

    function automatic int div_of(input int i);
        case (i)
            0:       return 5;
            1:       return 2;
            2:       return 127;
            default: return 100;
        endcase
    endfunction

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] limit;

    logic [NDUT-1:0]  tick_v;
    logic [NDUT-1:0]  timeout_v;
    logic [NDUT-1:0]  busy_v;
    logic [CNT_W-1:0] count_v [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        lfsr_interval_timer #(
            .LFSR_W   (7),
            .TICK_DIV (div_of(g)),
            .CNT_W    (CNT_W)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .stop    (stop),
            .mode    (mode),
            .limit   (limit),
            .tick    (tick_v[g]),
            .count   (count_v[g]),
            .timeout (timeout_v[g]),
            .busy    (busy_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                         tag;
        logic [NDUT-1:0][CNT_W-1:0] cnt;
        logic [NDUT-1:0]            tk;
        logic [NDUT-1:0]            bz;
    } snap_t;

    typedef struct {
        int tag;
        int dut;
    } to_t;

    snap_t snap_q[$];
    to_t   to_q[$];

    int n_edge = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    // Reference model: an interval is described by the edge at which it was
    // (re)started; base ticks fall on every multiple of the divider after it.
    int m_run   [NDUT];
    int m_per   [NDUT];
    int m_lim   [NDUT];
    int m_start [NDUT];
    int m_cnt   [NDUT];
    int m_tick  [NDUT];

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            m_run[d] = 0; m_per[d] = 0; m_lim[d] = 0;
            m_start[d] = 0; m_cnt[d] = 0; m_tick[d] = 0;
        end
    end

    task automatic step(input logic s, input logic p, input logic md,
                        input logic [CNT_W-1:0] lm, input logic r);
        snap_t sn;
        to_t   te;
        int    tag;
        bit    ok;
        @(negedge clk);
        start = s; stop = p; mode = md; limit = lm; rst = r;
        tag = n_edge + 1;
        ok  = s && !p && (lm != 0);
        for (int d = 0; d < NDUT; d++) begin
            int tprev;
            int fire;
            tprev     = m_tick[d];
            fire      = 0;
            m_tick[d] = 0;
            if (!r) begin
                m_run[d] = 0;
                m_cnt[d] = 0;
            end else if (ok) begin
                m_run[d]   = 1;
                m_lim[d]   = int'(lm);
                m_per[d]   = int'(md);
                m_start[d] = tag;
                m_cnt[d]   = 0;
            end else if (m_run[d] != 0 && p) begin
                m_run[d] = 0;
                m_cnt[d] = 0;
            end else if (m_run[d] != 0) begin
                if (tprev != 0) begin
                    if (m_cnt[d] + 1 == m_lim[d]) begin
                        m_cnt[d] = 0;
                        fire     = 1;
                        if (m_per[d] == 0) m_run[d] = 0;
                    end else begin
                        m_cnt[d] = m_cnt[d] + 1;
                    end
                end
                if (m_run[d] != 0 && ((tag - m_start[d]) % div_of(d)) == 0)
                    m_tick[d] = 1;
            end
            sn.cnt[d] = CNT_W'(m_cnt[d]);
            sn.tk[d]  = (m_tick[d] != 0);
            sn.bz[d]  = (m_run[d] != 0);
            if (fire != 0) begin
                te.tag = tag;
                te.dut = d;
                to_q.push_back(te);
            end
        end
        sn.tag = tag;
        snap_q.push_back(sn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, 15)), 1'b1);
    endtask

    // Monitor: status is compared every cycle, timeouts only when a DUT pulses.
    initial begin
        snap_t sn;
        to_t   te;
        forever begin
            @(posedge clk);
            n_edge++;
            #1;
            if (snap_q.size() > 0 && snap_q[0].tag == n_edge) begin
                sn = snap_q.pop_front();
                for (int d = 0; d < NDUT; d++) begin
                    n_cmp++;
                    if ({tick_v[d], busy_v[d], count_v[d]} !== {sn.tk[d], sn.bz[d], sn.cnt[d]}) begin
                        n_bad++;
                        $display("FAIL status dut%0d edge %0d: got tick=%b busy=%b count=%0d, want tick=%b busy=%b count=%0d",
                                 d, n_edge, tick_v[d], busy_v[d], count_v[d], sn.tk[d], sn.bz[d], sn.cnt[d]);
                    end
                end
            end
            for (int d = 0; d < NDUT; d++) begin
                if (timeout_v[d] === 1'b1) begin
                    n_cmp++;
                    if (to_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL timeout dut%0d: got pulse at edge %0d, want none", d, n_edge);
                    end else begin
                        te = to_q.pop_front();
                        if (te.tag != n_edge || te.dut != d) begin
                            n_bad++;
                            $display("FAIL timeout dut%0d: got pulse at edge %0d, want dut%0d at edge %0d",
                                     d, n_edge, te.dut, te.tag);
                        end
                    end
                end
            end
            while (to_q.size() > 0 && to_q[0].tag <= n_edge) begin
                te = to_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL timeout dut%0d: got no pulse, want pulse at edge %0d", te.dut, te.tag);
            end
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = '0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(5);

        // one-shot, limit 10
        step(1'b1, 1'b0, 1'b0, 4'd10, 1'b1);
        idle(1100);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        idle(3);

        // periodic, limit 3
        step(1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
        idle(50);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        idle(3);

        // stop coinciding with the final tick of the fast instance
        step(1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
        idle(15);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        idle(5);

        // restart with a new limit mid-interval
        step(1'b1, 1'b0, 1'b0, 4'd4, 1'b1);
        idle(11);
        step(1'b1, 1'b0, 1'b0, 4'd2, 1'b1);
        idle(20);

        // limit 0 ignored; reset mid-run
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(10);
        step(1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
        idle(20);
        step(1'b1, 1'b1, 1'b1, 4'd7, 1'b1);
        step(1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
        idle(8);
        step(1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
        idle(300);

        // periodic limit 1: timeout period equals the divider
        step(1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
        idle(600);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);

        // maximum limit
        step(1'b1, 1'b0, 1'b1, 4'd15, 1'b1);
        idle(170);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);

        for (int i = 0; i < 20000; i++) begin
            step(1'($urandom_range(0, 99) < 1),
                 1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 1)),
                 CNT_W'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1999) != 0));
        end
        idle(3);

        @(posedge clk);
        @(posedge clk);
        #2;
        while (to_q.size() > 0) begin
            to_t te;
            te = to_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL timeout dut%0d: got no pulse, want pulse at edge %0d", te.dut, te.tag);
        end
        n_cmp++;
        if (snap_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked status entries, want 0", snap_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
